// File: rtl/zl_rs_encoder_pkg.sv
// Shared DVB transport-stream constants and GF(256) helpers for the RS(204,188) path.
package zl_rs_encoder_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t       SYNC_BYTE     = 8'h47;
  localparam byte_t       SYNC_BYTE_INV = 8'hB8;
  localparam int unsigned RS_DATA_LEN   = 188;
  localparam int unsigned RS_CODE_LEN   = 204;
  localparam int unsigned RS_PARITY_LEN = RS_CODE_LEN - RS_DATA_LEN;

  // Field polynomial x^8+x^4+x^3+x^2+1; the low byte is what folds back on overflow.
  localparam int unsigned GF_POLY     = 32'h0000_011D;
  localparam byte_t       GF_POLY_LOW = 8'(GF_POLY);

  // Generator polynomial coefficients g_0..g_15 (leading x^16 term is implicit).
  localparam byte_t RS_GEN [RS_PARITY_LEN] = '{
    8'd59,  8'd36,  8'd50,  8'd98,  8'd229, 8'd41,  8'd65,  8'd163,
    8'd8,   8'd30,  8'd209, 8'd68,  8'd189, 8'd104, 8'd13,  8'd59
  };

  typedef enum logic {
    ST_DATA   = 1'b0,
    ST_PARITY = 1'b1
  } state_t;

  // Multiply by alpha (x) in GF(256).
  function automatic byte_t gf_xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY_LOW : 8'h00);
  endfunction

endpackage

// File: rtl/zl_gf256_const_mul.sv
// Combinational GF(256) multiply of a byte by a fixed constant.
module zl_gf256_const_mul
  import zl_rs_encoder_pkg::*;
#(
  parameter byte_t Coef = 8'h01
) (
  input  logic [7:0] a,
  output logic [7:0] y_c
);

  byte_t acc;
  byte_t term;

  // Shift-and-add over the set bits of the constant; collapses to an XOR network.
  always_comb begin
    acc  = '0;
    term = a;
    for (int k = 0; k < 8; k++) begin
      if (Coef[k]) acc = acc ^ term;
      term = gf_xtime(term);
    end
    y_c = acc;
  end

endmodule

// File: rtl/zl_rs_encoder.sv
// Systematic RS(204,188,t=8) encoder: passes payload through, then appends 16 parity bytes.
module zl_rs_encoder
  import zl_rs_encoder_pkg::*;
#(
  parameter bit          Sync_check = 1'b1,
  parameter int unsigned Data_len   = RS_DATA_LEN,
  parameter int unsigned Parity_len = RS_PARITY_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in_req,
  output logic       data_in_ack,
  input  logic [7:0] data_in,
  output logic       data_out_req,
  input  logic       data_out_ack,
  output logic [7:0] data_out
);

  localparam int unsigned CNT_W = $clog2((Data_len > Parity_len) ? Data_len : Parity_len);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  byte_t            par [Parity_len];
  byte_t            tap [Parity_len];
  byte_t            fb;

  logic out_free;
  logic is_sync;
  logic drop;
  logic accept;
  logic take;
  logic par_shift;
  logic last_data;
  logic last_par;

  // Handshake and event decode shared by the FSM and the datapath.
  assign out_free  = !data_out_req || data_out_ack;
  assign is_sync   = (data_in == SYNC_BYTE) || (data_in == SYNC_BYTE_INV);
  assign drop      = Sync_check && (count == '0) && !is_sync;
  assign accept    = data_in_req && data_in_ack;
  assign take      = accept && !drop;
  assign par_shift = (state == ST_PARITY) && out_free;
  assign last_data = take && (count == CNT_W'(Data_len - 1));
  assign last_par  = par_shift && (count == CNT_W'(Parity_len - 1));
  assign fb        = data_in ^ par[Parity_len-1];

  // One constant multiplier per LFSR tap.
  for (genvar i = 0; i < Parity_len; i++) begin : g_tap
    zl_gf256_const_mul #(.Coef(RS_GEN[i])) u_mul (
      .a   (fb),
      .y_c (tap[i])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_DATA;
    else        state <= state_next;
  end

  // Next-state: payload phase ends on the last data byte, parity phase on the last parity byte.
  always_comb begin
    state_next = state;
    case (state)
      ST_DATA:   if (last_data) state_next = ST_PARITY;
      ST_PARITY: if (last_par)  state_next = ST_DATA;
      default:   state_next = ST_DATA;
    endcase
  end

  // Input is only accepted during the payload phase and when the output slot can take it.
  always_comb begin
    data_in_ack = 1'b0;
    case (state)
      ST_DATA:   data_in_ack = out_free;
      ST_PARITY: data_in_ack = 1'b0;
      default:   data_in_ack = 1'b0;
    endcase
  end

  // Output register, byte counter and parity LFSR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out     <= '0;
      data_out_req <= 1'b0;
      count        <= '0;
      for (int i = 0; i < Parity_len; i++) par[i] <= '0;
    end else if (take) begin
      data_out     <= data_in;
      data_out_req <= 1'b1;
      count        <= last_data ? '0 : count + CNT_W'(1);
      par[0]       <= tap[0];
      for (int i = 1; i < Parity_len; i++) par[i] <= par[i-1] ^ tap[i];
    end else if (par_shift) begin
      data_out     <= par[Parity_len-1];
      data_out_req <= 1'b1;
      count        <= last_par ? '0 : count + CNT_W'(1);
      par[0]       <= '0;
      for (int i = 1; i < Parity_len; i++) par[i] <= par[i-1];
    end else if (out_free) begin
      data_out_req <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zl_rs_encoder.sv
// Self-checking bench for zl_rs_encoder against a polynomial-division RS(204,188) model.
module tb_zl_rs_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       in_req = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ack = 1'b0;

  logic       ack0, ack1, oreq0, oreq1;
  logic [7:0] dout0, dout1;
  logic       in_ack, out_req;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] src_q[$];
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  int         hold_err = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  int exp_t[256];
  int log_t[256];
  int gen[17];

  always #5 clk = ~clk;

  // DUT 0 forwards every byte; DUT 1 hunts for the sync byte.
  zl_rs_encoder #(.Sync_check(1'b0)) dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in_req  (in_req & ~sel),
    .data_in_ack  (ack0),
    .data_in      (in_data),
    .data_out_req (oreq0),
    .data_out_ack (out_ack & ~sel),
    .data_out     (dout0)
  );

  zl_rs_encoder #(.Sync_check(1'b1)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in_req  (in_req & sel),
    .data_in_ack  (ack1),
    .data_in      (in_data),
    .data_out_req (oreq1),
    .data_out_ack (out_ack & sel),
    .data_out     (dout1)
  );

  assign in_ack   = sel ? ack1  : ack0;
  assign out_req  = sel ? oreq1 : oreq0;
  assign out_data = sel ? dout1 : dout0;

  // Collect transferred output bytes and watch output stability under back-pressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (!out_req || out_data !== prev_data)) hold_err++;
      if (out_req && out_ack) out_q.push_back(out_data);
      prev_hold = out_req && !out_ack;
      prev_data = out_data;
    end
  end

  function automatic int gf_mul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  // Log/antilog tables and g(x) = prod (x + alpha^i), i = 0..15.
  task automatic init_model();
    int e;
    int nxt[17];
    e = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e;
      log_t[e] = i;
      e = e << 1;
      if ((e & 'h100) != 0) e = e ^ 'h11D;
    end
    for (int j = 0; j < 17; j++) gen[j] = 0;
    gen[0] = 1;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 17; j++) begin
        nxt[j] = gf_mul(gen[j], exp_t[i]);
        if (j > 0) nxt[j] = nxt[j] ^ gen[j-1];
      end
      gen = nxt;
    end
  endtask

  // Append the expected codeword for src_q[base +: 188]: payload, then (M(x)*x^16 mod g(x)).
  task automatic model_push(input int base);
    int r[204];
    int c;
    for (int k = 0; k < 204; k++) r[k] = 0;
    for (int k = 0; k < 188; k++) r[203-k] = int'(src_q[base+k]);
    for (int d = 203; d >= 16; d--) begin
      c = r[d];
      if (c != 0) for (int j = 0; j <= 16; j++) r[d-16+j] = r[d-16+j] ^ gf_mul(c, gen[j]);
    end
    for (int k = 0; k < 188; k++) exp_q.push_back(src_q[base+k]);
    for (int j = 0; j < 16; j++) exp_q.push_back(8'(r[15-j]));
  endtask

  function automatic int first_diff(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      if (i >= out_q.size() || i >= exp_q.size()) return i;
      if (out_q[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    return (i < out_q.size()) ? out_q[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return (i < exp_q.size()) ? exp_q[i] : 8'hxx;
  endfunction

  task automatic push_packet(input logic sync_first);
    logic [7:0] b;
    b = ($urandom_range(1) == 0) ? 8'h47 : 8'hB8;
    src_q.push_back(sync_first ? b : 8'($urandom));
    for (int k = 1; k < 188; k++) src_q.push_back(8'($urandom));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n   = 1'b0;
    in_req  = 1'b0;
    out_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    out_q.delete();
    exp_q.delete();
    src_q.delete();
    hold_err = 0;
  endtask

  // Drive src_q[0 +: n] with random gaps and random output ack until exp_out bytes are collected.
  task automatic run_stream(input int n, input int req_pct, input int ack_pct, input int exp_out,
                            input int budget, output int cycles, output int stalls);
    int idx;
    idx    = 0;
    cycles = 0;
    stalls = 0;
    while (1) begin
      @(posedge clk); #1;
      in_req  = (idx < n) && ($urandom_range(99) < req_pct);
      in_data = in_req ? src_q[idx] : 8'($urandom);
      out_ack = ($urandom_range(99) < ack_pct);
      @(negedge clk); #1;
      cycles++;
      if (in_req && !in_ack) stalls++;
      if (in_req && in_ack) idx++;
      if (idx >= n && out_q.size() >= exp_out) break;
      if (cycles >= budget) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout: accepted %0d of %0d, collected %0d of %0d", idx, n, out_q.size(), exp_out);
        break;
      end
    end
    @(posedge clk); #1;
    in_req  = 1'b0;
    out_ack = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (oreq0 !== 1'b0 || oreq1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_req: got %b/%b exp 0/0", oreq0, oreq1);
    end
    checks++;
    if (dout0 !== 8'h00 || dout1 !== 8'h00) begin
      errors++;
      $display("FAIL reset_data_out: got %h/%h exp 00/00", dout0, dout1);
    end
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ack: got %b/%b exp 1/1", ack0, ack1);
    end
  endtask

  task automatic test_impulse();
    logic [7:0] gref[16];
    int cyc, stl, d;
    gref = '{8'd59, 8'd13, 8'd104, 8'd189, 8'd68, 8'd209, 8'd30, 8'd8,
             8'd163, 8'd65, 8'd41, 8'd229, 8'd98, 8'd50, 8'd36, 8'd59};
    sel = 1'b0;
    do_reset();
    for (int k = 0; k < 187; k++) src_q.push_back(8'h00);
    src_q.push_back(8'h01);
    src_q.push_back(8'hA5);
    for (int k = 0; k < 188; k++) exp_q.push_back(src_q[k]);
    for (int j = 0; j < 16; j++) exp_q.push_back(gref[j]);
    exp_q.push_back(8'hA5);
    run_stream(189, 100, 100, 205, 1000, cyc, stl);
    checks++;
    d = first_diff(0, 205);
    if (d >= 0 || out_q.size() != 205) begin
      errors++;
      $display("FAIL impulse_codeword: idx %0d got %h exp %h (size %0d exp 205)", d, got_at(d), exp_at(d), out_q.size());
    end
    checks++;
    if (stl != 16) begin
      errors++;
      $display("FAIL impulse_ack_low: got %0d cycles exp 16", stl);
    end
  endtask

  task automatic test_zero_packet();
    int cyc, stl, d;
    sel = 1'b0;
    do_reset();
    for (int k = 0; k < 188; k++) src_q.push_back(8'h00);
    push_packet(1'b0);
    for (int k = 0; k < 204; k++) exp_q.push_back(8'h00);
    model_push(188);
    run_stream(376, 100, 100, 408, 2000, cyc, stl);
    checks++;
    d = first_diff(0, 204);
    if (d >= 0) begin
      errors++;
      $display("FAIL zero_codeword: idx %0d got %h exp %h", d, got_at(d), exp_at(d));
    end
    checks++;
    d = first_diff(204, 408);
    if (d >= 0 || out_q.size() != 408) begin
      errors++;
      $display("FAIL zero_followup_residue: idx %0d got %h exp %h (size %0d exp 408)", d, got_at(d), exp_at(d), out_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc, stl, d;
    sel = 1'b1;
    do_reset();
    for (int p = 0; p < 8; p++) begin
      push_packet(1'b1);
      model_push(p * 188);
    end
    run_stream(8 * 188, 100, 100, 8 * 204, 5000, cyc, stl);
    for (int p = 0; p < 8; p++) begin
      checks++;
      d = first_diff(p * 204, (p + 1) * 204);
      if (d >= 0) begin
        errors++;
        $display("FAIL b2b_block%0d: idx %0d got %h exp %h", p, d, got_at(d), exp_at(d));
      end
    end
    checks++;
    if (out_q.size() != 8 * 204) begin
      errors++;
      $display("FAIL b2b_count: got %0d bytes exp %0d", out_q.size(), 8 * 204);
    end
    checks++;
    if (stl != 7 * 16) begin
      errors++;
      $display("FAIL b2b_stall_cycles: got %0d exp %0d", stl, 7 * 16);
    end
    checks++;
    if (cyc != 8 * 204 + 1) begin
      errors++;
      $display("FAIL b2b_rate_cycles: got %0d exp %0d", cyc, 8 * 204 + 1);
    end
  endtask

  task automatic test_sync_hunt();
    int cyc, stl, d;
    sel = 1'b1;
    do_reset();
    src_q.push_back(8'h12);
    src_q.push_back(8'h00);
    src_q.push_back(8'h47);
    for (int k = 1; k < 188; k++) src_q.push_back(8'($urandom));
    model_push(2);
    run_stream(190, 100, 100, 204, 1000, cyc, stl);
    checks++;
    if (got_at(0) !== 8'h47) begin
      errors++;
      $display("FAIL hunt_first_byte: got %h exp 47", got_at(0));
    end
    checks++;
    d = first_diff(0, 204);
    if (d >= 0 || out_q.size() != 204) begin
      errors++;
      $display("FAIL hunt_codeword: idx %0d got %h exp %h (size %0d exp 204)", d, got_at(d), exp_at(d), out_q.size());
    end
  endtask

  task automatic test_backpressure();
    int cyc, stl, d;
    sel = 1'b1;
    do_reset();
    for (int p = 0; p < 20; p++) begin
      push_packet(1'b1);
      model_push(p * 188);
    end
    run_stream(20 * 188, 70, 50, 20 * 204, 30000, cyc, stl);
    checks++;
    d = first_diff(0, 20 * 204);
    if (d >= 0 || out_q.size() != 20 * 204) begin
      errors++;
      $display("FAIL bp_stream: idx %0d got %h exp %h (size %0d exp %0d)", d, got_at(d), exp_at(d), out_q.size(), 20 * 204);
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL bp_hold_stable: got %0d violations exp 0", hold_err);
    end
  endtask

  task automatic test_mid_reset();
    int cyc, stl, d;
    sel = 1'b1;
    do_reset();
    push_packet(1'b1);
    run_stream(100, 100, 100, 100, 1000, cyc, stl);
    @(posedge clk); #1;
    out_ack = 1'b0;
    in_req  = 1'b1;
    in_data = 8'h47;
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_req !== 1'b0) begin
        errors++;
        $display("FAIL midreset_out_req cycle %0d: got %b exp 0", c, out_req);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_q.delete();
    exp_q.delete();
    src_q.delete();
    push_packet(1'b1);
    model_push(0);
    run_stream(188, 80, 60, 204, 3000, cyc, stl);
    checks++;
    d = first_diff(0, 204);
    if (d >= 0 || out_q.size() != 204) begin
      errors++;
      $display("FAIL midreset_fresh_packet: idx %0d got %h exp %h (size %0d exp 204)", d, got_at(d), exp_at(d), out_q.size());
    end
  endtask

  initial begin
    init_model();
    test_reset();
    test_impulse();
    test_zero_packet();
    test_back_to_back();
    test_sync_hunt();
    test_backpressure();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
